// File: rtl/vend_pkg.sv
// Shared constants for the vending front end: coin codes and values, price table, state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_1C  = 2'b00;
  localparam logic [1:0] COIN_5C  = 2'b01;
  localparam logic [1:0] COIN_10C = 2'b10;
  localparam logic [1:0] COIN_25C = 2'b11;

  localparam logic [6:0] CENTS_1  = 7'd1;
  localparam logic [6:0] CENTS_5  = 7'd5;
  localparam logic [6:0] CENTS_10 = 7'd10;
  localparam logic [6:0] CENTS_25 = 7'd25;

  localparam logic [6:0] PRICE_ITEM0 = 7'd64;
  localparam logic [6:0] PRICE_ITEM1 = 7'd54;
  localparam logic [6:0] PRICE_ITEM2 = 7'd27;
  localparam logic [6:0] PRICE_ITEM3 = 7'd63;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COLLECT   = 2'd1;
  localparam logic [1:0] ST_LAUNCH    = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    COLLECT   = ST_COLLECT,
    LAUNCH    = ST_LAUNCH,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  function automatic logic [6:0] price_of(input logic [1:0] item);
    case (item)
      2'd0:    return PRICE_ITEM0;
      2'd1:    return PRICE_ITEM1;
      2'd2:    return PRICE_ITEM2;
      default: return PRICE_ITEM3;
    endcase
  endfunction

endpackage

// File: rtl/coin_value_decode.sv
// Combinational map from the 2-bit coin code to its value in cents.
module coin_value_decode
  import vend_pkg::*;
(
  input  logic [1:0] coin_type,
  output logic [6:0] cents
);

  always_comb begin
    case (coin_type)
      COIN_1C:  cents = CENTS_1;
      COIN_5C:  cents = CENTS_5;
      COIN_10C: cents = CENTS_10;
      default:  cents = CENTS_25;
    endcase
  end

endmodule

// File: rtl/vend_credit_collector.sv
// Coin collection, selection check and transaction hand-off to the change FSM.
// All outputs are flops; money/price stay frozen from LAUNCH until done is seen after a low.
module vend_credit_collector
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       done,
  output logic [6:0] money,
  output logic [6:0] price,
  output logic       start,
  output logic [6:0] credit,
  output logic       busy,
  output logic       reject,
  output logic       insufficient
);

  localparam logic [7:0] MAX8 = 8'(MAX_CREDIT);

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [6:0] money_q, money_d;
  logic [6:0] price_q, price_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       reject_q, reject_d;
  logic       insuff_q, insuff_d;
  logic       armed_q, armed_d;

  logic [6:0] coin_cents;
  logic [6:0] item_price;
  logic [7:0] coin_sum;

  coin_value_decode u_coin_dec (
    .coin_type (coin_type),
    .cents     (coin_cents)
  );

  assign item_price = price_of(sel_item);
  // Widened add so an over-limit coin is caught instead of wrapping.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_cents};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    money_d  = money_q;
    price_d  = price_q;
    armed_d  = armed_q;
    reject_d = 1'b0;
    insuff_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && (credit_q != 7'd0)) begin
          money_d  = credit_q;
          price_d  = 7'd0;
          state_d  = LAUNCH;
          reject_d = coin_valid;
        end else if (sel_valid && (credit_q >= item_price)) begin
          money_d  = credit_q;
          price_d  = item_price;
          state_d  = LAUNCH;
          reject_d = coin_valid;
        end else begin
          insuff_d = sel_valid;
          if (coin_valid) begin
            if (coin_sum <= MAX8) begin
              credit_d = coin_sum[6:0];
              state_d  = COLLECT;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      end
      LAUNCH: begin
        armed_d  = 1'b0;
        reject_d = coin_valid;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        reject_d = coin_valid;
        // A done level left over from the last transaction must drop before it counts.
        if (armed_q && done) begin
          credit_d = 7'd0;
          money_d  = 7'd0;
          price_d  = 7'd0;
          armed_d  = 1'b0;
          state_d  = IDLE;
        end else if (!done) begin
          armed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == LAUNCH);
    busy_d  = (state_d == LAUNCH) || (state_d == WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= 7'd0;
      money_q  <= 7'd0;
      price_q  <= 7'd0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      insuff_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      money_q  <= money_d;
      price_q  <= price_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
      insuff_q <= insuff_d;
      armed_q  <= armed_d;
    end
  end

  assign money        = money_q;
  assign price        = price_q;
  assign start        = start_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign reject       = reject_q;
  assign insufficient = insuff_q;

endmodule

// File: tb/tb_vend_credit_collector.sv
// Cycle-by-cycle vector table with a scoreboard queue, plus a bounded hand-off sequence.
module tb_vend_credit_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       done;
  logic [6:0] money, price, credit;
  logic       start, busy, reject, insufficient;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_credit_collector #(.MAX_CREDIT(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .done         (done),
    .money        (money),
    .price        (price),
    .start        (start),
    .credit       (credit),
    .busy         (busy),
    .reject       (reject),
    .insufficient (insufficient)
  );

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] si;
    logic       can;
    logic       dn;
    logic [6:0] e_credit;
    logic [6:0] e_money;
    logic [6:0] e_price;
    logic       e_start;
    logic       e_busy;
    logic       e_rej;
    logic       e_ins;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input logic rst, input logic cv, input logic [1:0] ct,
                     input logic sv, input logic [1:0] si, input logic can, input logic dn,
                     input logic [6:0] cr, input logic [6:0] mo, input logic [6:0] pr,
                     input logic st, input logic bz, input logic rj, input logic ins);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ct = ct; v.sv = sv; v.si = si; v.can = can; v.dn = dn;
    v.e_credit = cr; v.e_money = mo; v.e_price = pr;
    v.e_start = st; v.e_busy = bz; v.e_rej = rj; v.e_ins = ins;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s [%0d] got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; coin_valid = 1'b0; coin_type = 2'd0;
    sel_valid = 1'b0; sel_item = 2'd0; cancel = 1'b0; done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v, e;
    int   n_low;
    int   n_start;
    bit   exited;

    drive_idle();
    reset = 1'b1;
    step();
    step();

    // reset state, then IDLE select and cancel
    add(1,0,0,0,0,0,0,   0,  0,  0,0,0,0,0);
    add(0,0,0,1,0,0,0,   0,  0,  0,0,0,0,1);
    add(0,0,0,0,0,1,0,   0,  0,  0,0,0,0,0);
    // three quarters, buy item0, done low then high
    add(0,1,3,0,0,0,0,  25,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  50,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  75,  0,  0,0,0,0,0);
    add(0,0,0,1,0,0,0,  75, 75, 64,1,1,0,0);
    add(0,0,0,0,0,0,0,  75, 75, 64,0,1,0,0);
    add(0,0,0,0,0,0,0,  75, 75, 64,0,1,0,0);
    add(0,0,0,0,0,0,1,   0,  0,  0,0,0,0,0);
    // credit ceiling
    add(0,1,3,0,0,0,0,  25,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  50,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  75,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0, 100,  0,  0,0,0,0,0);
    add(0,1,0,0,0,0,0, 100,  0,  0,0,0,1,0);
    add(0,1,1,0,0,0,0, 100,  0,  0,0,0,1,0);
    add(0,0,0,0,0,1,0, 100,100,  0,1,1,0,0);
    add(0,0,0,0,0,0,0, 100,100,  0,0,1,0,0);
    add(0,0,0,0,0,0,0, 100,100,  0,0,1,0,0);
    add(0,0,0,0,0,0,1,   0,  0,  0,0,0,0,0);
    // insufficient credit for item3
    add(0,1,3,0,0,0,0,  25,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  50,  0,  0,0,0,0,0);
    add(0,0,0,1,3,0,0,  50,  0,  0,0,0,0,1);
    add(0,0,0,0,0,0,0,  50,  0,  0,0,0,0,0);
    add(0,0,0,0,0,1,0,  50, 50,  0,1,1,0,0);
    add(0,0,0,0,0,0,0,  50, 50,  0,0,1,0,0);
    add(0,0,0,0,0,0,0,  50, 50,  0,0,1,0,0);
    add(0,0,0,0,0,0,1,   0,  0,  0,0,0,0,0);
    // cancel beats select and coin in the same cycle
    add(0,1,3,0,0,0,0,  25,  0,  0,0,0,0,0);
    add(0,1,1,0,0,0,0,  30,  0,  0,0,0,0,0);
    add(0,1,1,1,2,1,0,  30, 30,  0,1,1,1,0);
    add(0,0,0,0,0,0,0,  30, 30,  0,0,1,0,0);
    add(0,0,0,0,0,0,0,  30, 30,  0,0,1,0,0);
    add(0,0,0,0,0,0,1,   0,  0,  0,0,0,0,0);
    // done stuck high across launch; coins rejected while busy
    add(0,1,3,0,0,0,1,  25,  0,  0,0,0,0,0);
    add(0,1,0,0,0,0,1,  26,  0,  0,0,0,0,0);
    add(0,1,0,0,0,0,1,  27,  0,  0,0,0,0,0);
    add(0,0,0,1,2,0,1,  27, 27, 27,1,1,0,0);
    add(0,1,3,0,0,0,1,  27, 27, 27,0,1,1,0);
    add(0,1,1,0,0,0,1,  27, 27, 27,0,1,1,0);
    add(0,0,0,0,0,0,1,  27, 27, 27,0,1,0,0);
    add(0,1,0,0,0,0,0,  27, 27, 27,0,1,1,0);
    add(0,0,0,0,0,0,1,   0,  0,  0,0,0,0,0);
    // reset while waiting for done
    add(0,1,3,0,0,0,0,  25,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  50,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0,  75,  0,  0,0,0,0,0);
    add(0,1,3,0,0,0,0, 100,  0,  0,0,0,0,0);
    add(0,0,0,1,0,0,0, 100,100, 64,1,1,0,0);
    add(0,0,0,0,0,0,0, 100,100, 64,0,1,0,0);
    add(1,0,0,0,0,0,0,   0,  0,  0,0,0,0,0);
    add(0,1,2,0,0,0,0,  10,  0,  0,0,0,0,0);
    add(0,0,0,1,1,0,0,  10,  0,  0,0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; coin_valid = v.cv; coin_type = v.ct;
      sel_valid = v.sv; sel_item = v.si; cancel = v.can; done = v.dn;
      exp_q.push_back(v);
      step();
      e = exp_q.pop_front();
      chk("credit", i, {1'b0, credit}, {1'b0, e.e_credit});
      chk("money",  i, {1'b0, money},  {1'b0, e.e_money});
      chk("price",  i, {1'b0, price},  {1'b0, e.e_price});
      chk("start",  i, {7'd0, start},  {7'd0, e.e_start});
      chk("busy",   i, {7'd0, busy},   {7'd0, e.e_busy});
      chk("reject", i, {7'd0, reject}, {7'd0, e.e_rej});
      chk("insuff", i, {7'd0, insufficient}, {7'd0, e.e_ins});
    end

    // Hand-off with a random-length done-low gap and a bounded wait for completion.
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    coin_valid = 1'b1; coin_type = 2'd3;
    step();
    step();
    coin_valid = 1'b0;
    sel_valid = 1'b1; sel_item = 2'd2;
    step();
    sel_valid = 1'b0;
    chk("hs_start", 0, {7'd0, start}, 8'd1);
    chk("hs_money", 0, {1'b0, money}, 8'd50);
    chk("hs_price", 0, {1'b0, price}, 8'd27);
    n_low = $urandom_range(1, 4);
    n_start = 0;
    done = 1'b0;
    for (int k = 0; k < n_low + 1; k++) begin
      step();
      if (start) n_start++;
      chk("hs_busy_hold", k, {7'd0, busy}, 8'd1);
      chk("hs_money_hold", k, {1'b0, money}, 8'd50);
    end
    done = 1'b1;
    exited = 1'b0;
    for (int k = 0; k < 10 && !exited; k++) begin
      step();
      if (start) n_start++;
      if (!busy) exited = 1'b1;
    end
    chk("hs_exit", 0, {7'd0, exited}, 8'd1);
    chk("hs_extra_start", 0, 8'(n_start), 8'd0);
    chk("hs_credit", 0, {1'b0, credit}, 8'd0);
    chk("hs_money_clr", 0, {1'b0, money}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
